// File: rtl/pipo_load_arbiter_if.sv
// Request/acknowledge and holding-register bundle for pipo_load_arbiter.
// Requesters sit on the master side, the arbiter on the slave side.
interface pipo_load_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      parallel_out;
    logic                  load_en;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    modport master (
        output req, req_data,
        input  ack, parallel_out, load_en, grant_id, busy
    );

    modport slave (
        input  req, req_data,
        output ack, parallel_out, load_en, grant_id, busy
    );
endinterface

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter loading one shared PIPO register, 4-phase req/ack.
// PIPO_ARB_PRIO_EN: requester 0 gets fixed top priority without moving ptr.
module pipo_load_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               reset,
    pipo_load_arbiter_if.slave bus
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t           state, state_n;
    logic [IDW-1:0]   ptr, ptr_n;
    logic [IDW-1:0]   win, win_inc;
    logic             found;
    logic [NREQ-1:0]  ack, ack_n;
    logic [WIDTH-1:0] pout, pout_n;
    logic             load_en, load_en_n;
    logic [IDW-1:0]   grant_id, grant_id_n;
    logic             busy, busy_n;

    // Scan ptr, ptr+1, ... wrapping, first set bit wins
    always_comb begin
        int j;
        j     = 0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req[j]) begin
                win   = IDW'(j);
                found = 1'b1;
            end
        end
`ifdef PIPO_ARB_PRIO_EN
        if (bus.req[0]) win = '0;
`endif
    end

    assign win_inc = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        ack_n      = ack;
        pout_n     = pout;
        load_en_n  = 1'b0;
        grant_id_n = grant_id;
        busy_n     = busy;
        unique case (state)
            IDLE: begin
                if (found) begin
                    pout_n      = bus.req_data[int'(win)*WIDTH +: WIDTH];
                    ack_n       = '0;
                    ack_n[win]  = 1'b1;
                    load_en_n   = 1'b1;
                    grant_id_n  = win;
                    busy_n      = 1'b1;
                    state_n     = ACK;
`ifdef PIPO_ARB_PRIO_EN
                    if (!bus.req[0]) ptr_n = win_inc;
`else
                    ptr_n = win_inc;
`endif
                end
            end
            ACK: begin
                if (!bus.req[grant_id]) begin
                    ack_n   = '0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            ack      <= '0;
            pout     <= '0;
            load_en  <= 1'b0;
            grant_id <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            ack      <= ack_n;
            pout     <= pout_n;
            load_en  <= load_en_n;
            grant_id <= grant_id_n;
            busy     <= busy_n;
        end
    end

    assign bus.ack          = ack;
    assign bus.parallel_out = pout;
    assign bus.load_en      = load_en;
    assign bus.grant_id     = grant_id;
    assign bus.busy         = busy;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Scoreboard bench for pipo_load_arbiter: expected grants are queued from a
// reference round-robin model when requests are raised, checked on load_en.
module tb_pipo_load_arbiter;

    logic clk;
    logic reset;
    int   nvec;
    int   nerr;
    int   mptr;
    logic [7:0] sbq[$];

    pipo_load_arbiter_if #(.NREQ(4), .WIDTH(4), .IDW(2)) bus ();

    pipo_load_arbiter #(.NREQ(4), .WIDTH(4), .IDW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
`ifdef PIPO_ARB_PRIO_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Queue the grant order for a set of requesters that each drop on ack
    task automatic push_seq(input logic [3:0] r);
        logic [3:0] pend;
        int w;
        pend = r;
        while (pend != 4'b0) begin
            w = pick(pend, mptr);
            sbq.push_back({4'(w), bus.req_data[w*4 +: 4]});
`ifdef PIPO_ARB_PRIO_EN
            if (w != 0) mptr = (w + 1) % 4;
`else
            mptr = (w + 1) % 4;
`endif
            pend[w] = 1'b0;
        end
    endtask

    task automatic wait_load(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.load_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = bus.load_en;
        if (!ok) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic serve(input bit rearm);
        bit ok;
        logic [7:0] e;
        int id;
        wait_load(ok);
        if (!ok) return;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e  = sbq.pop_front();
        id = int'(e[7:4]);
        chk("grant_id", 32'(bus.grant_id), 32'(id));
        chk("load_data", 32'(bus.parallel_out), 32'(e[3:0]));
        chk("ack_onehot", 32'(bus.ack), 32'(1 << id));
        chk("busy_set", 32'(bus.busy), 32'd1);
        bus.req_data[id*4 +: 4] = ~e[3:0];
        @(negedge clk);
        chk("load_pulse", 32'(bus.load_en), 32'd0);
        chk("data_hold", 32'(bus.parallel_out), 32'(e[3:0]));
        chk("ack_hold", 32'(bus.ack), 32'(1 << id));
        bus.req_data[id*4 +: 4] = e[3:0];
        bus.req[id] = 1'b0;
        @(negedge clk);
        chk("ack_drop", 32'(bus.ack), 32'd0);
        chk("busy_drop", 32'(bus.busy), 32'd0);
        if (rearm) bus.req[id] = 1'b1;
    endtask

    initial begin
        bit ok;
        logic [7:0] e;
        nvec = 0;
        nerr = 0;
        mptr = 0;
        reset = 1'b0;
        bus.req = 4'b1111;
        bus.req_data = {4'b0110, 4'b0101, 4'b1001, 4'b0001};
        repeat (3) @(negedge clk);
        chk("rst_pout", 32'(bus.parallel_out), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_load", 32'(bus.load_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_gid", 32'(bus.grant_id), 32'd0);

        reset = 1'b1;
        mptr = 0;
        push_seq(4'b1111);
        repeat (4) serve(1'b0);

        bus.req = 4'b0001;
        push_seq(4'b0001);
        serve(1'b0);

        bus.req_data[11:8] = 4'b1011;
        bus.req = 4'b0100;
        push_seq(4'b0100);
        serve(1'b0);

        bus.req_data[15:12] = 4'b0110;
        bus.req = 4'b1000;
        push_seq(4'b1000);
        serve(1'b0);

        bus.req = 4'b0010;
        push_seq(4'b0010);
        wait_load(ok);
        if (ok && sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("mid_gid", 32'(bus.grant_id), 32'(e[7:4]));
            chk("mid_ack", 32'(bus.ack), 32'(1 << int'(e[7:4])));
        end
        #2 reset = 1'b0;
        #1;
        chk("async_ack", 32'(bus.ack), 32'd0);
        chk("async_pout", 32'(bus.parallel_out), 32'd0);
        chk("async_busy", 32'(bus.busy), 32'd0);
        mptr = 0;
        bus.req = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        bus.req = 4'b0001;
        push_seq(4'b0001);
        serve(1'b0);

        bus.req = 4'b1001;
        for (int t = 0; t < 4; t++) begin
            sbq.push_back({4'(pick(4'b1001, mptr)),
                           bus.req_data[pick(4'b1001, mptr)*4 +: 4]});
`ifdef PIPO_ARB_PRIO_EN
            if (pick(4'b1001, mptr) != 0) mptr = (pick(4'b1001, mptr) + 1) % 4;
`else
            mptr = (pick(4'b1001, mptr) + 1) % 4;
`endif
            serve(1'b1);
        end
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
